// File: rtl/wishbone_pkg.sv
// Shared constants for the Wishbone classic initiator: FSM encoding,
// bus widths and the default timeout data pattern.
package wishbone_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/wishbone_master.sv
// Single-transaction Wishbone classic initiator: accepts one command, runs one
// bus cycle with an ack timeout, then reports the result with a one-cycle pulse.
module wishbone_master
  import wishbone_pkg::*;
#(
  parameter int                TIMEOUT  = 256,
  parameter logic [DATA_W-1:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [SEL_W-1:0]  cmd_sel,

  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,

  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [DATA_W-1:0] wbm_dat_i
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              we_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [ADDR_W-1:0] adr_reg;
  logic [DATA_W-1:0] dat_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_err_reg;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      we_reg       <= 1'b0;
      sel_reg      <= '0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            we_reg    <= cmd_we;
            sel_reg   <= cmd_sel;
            adr_reg   <= cmd_addr;
            dat_reg   <= cmd_data;
            cnt_reg   <= '0;
            state_reg <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ack is tested first so it wins over a timeout in the same cycle.
          if (wbm_ack_i) begin
            if (!we_reg) begin
              rsp_data_reg <= wbm_dat_i;
            end
            rsp_err_reg <= 1'b0;
            state_reg   <= ST_RESP;
          end else if (cnt_reg == CNT_LAST) begin
            rsp_data_reg <= ERR_DATA;
            rsp_err_reg  <= 1'b1;
            state_reg    <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Decoded straight from state so reset clears the strobes without a clock.
  assign cmd_ready = (state_reg == ST_IDLE);
  assign wbm_cyc_o = (state_reg == ST_BUS);
  assign wbm_stb_o = (state_reg == ST_BUS);
  assign rsp_valid = (state_reg == ST_RESP);

  assign wbm_we_o  = we_reg;
  assign wbm_sel_o = sel_reg;
  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = dat_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

endmodule
